baccarat_deal_fsm: RTL and testbench
====================================

# baccarat_deal_fsm

Sequencing controller for the baccarat datapath. Issues one card-load strobe per `slow_clock` cycle to the player and dealer card registers in dealing order. Applies the baccarat third-card rules to the 0–9 hand scores produced by the datapath's scoring logic, then lights the win indicators. The datapath holds the six card registers and the two scorers; this block owns only the game sequence.

## Interface
Parameters:
- `HOLD_CYCLES`, default 8: number of DONE cycles before a redeal; used only when `AUTO_REDEAL_EN` is defined.

Ports:
- `slow_clock` input 1: single clock, all state changes on its rising edge.
- `resetb` input 1: reset, asynchronous and active-low.
- `pscore` input 4: player hand score 0–9, combinational from the player card registers.
- `dscore` input 4: dealer hand score 0–9, combinational from the dealer card registers.
- `pcard3` input 4: raw player third-card code (1=A … 13=K; 0 = no card).
- `load_pcard1`, `load_pcard2`, `load_pcard3` output 1 each: player card-register load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3` output 1 each: dealer card-register load strobes.
- `clear_hand` output 1: one-cycle pulse that clears all six card registers before a redeal.
- `player_win_light`, `dealer_win_light` output 1 each: result indicators.

## Operation
- States: RST, P1, D1, P2, D2, CHECK, P3, BCHK, D3, DONE.
- Outputs are Moore decodes of the state:
  - P1→`load_pcard1`, D1→`load_dcard1`, P2→`load_pcard2`, D2→`load_dcard2`, P3→`load_pcard3`, D3→`load_dcard3`.
  - Each strobe is high for exactly that one state.
- Fixed transitions: RST→P1→D1→P2→D2→CHECK.
- CHECK:
  - Natural: `pscore`≥8 or `dscore`≥8 → DONE.
  - Else `pscore`≤5 → P3.
  - Else (player stands at 6–7): `dscore`≤5 → D3; otherwise DONE.
- P3→BCHK.
- BCHK: banker rule, where v = card value of `pcard3`.
  - v = `pcard3` for codes 1–9; v = 0 for codes 0 and 10–15.
  - `dscore` 0–2: draw.
  - 3: draw unless v = 8.
  - 4: draw if v in 2–7.
  - 5: draw if v in 4–7.
  - 6: draw if v in 6–7.
  - 7–9: stand.
  - Draw → D3; stand → DONE.
- D3→DONE.
- DONE:
  - `player_win_light` = (`pscore` > `dscore`) or tie.
  - `dealer_win_light` = (`dscore` > `pscore`) or tie.
  - A tie lights both.
  - Lights are 0 in every other state.
- Score comparisons are unsigned 4-bit.
- `pscore` and `dscore` are trusted to be 0–9. Values 10–15 are treated as ≥8 (natural) in CHECK and as "stand" in BCHK.

## Timing
- Reset:
  - `resetb` low forces RST immediately, mid-game included.
  - In RST: all strobes, `clear_hand` and lights are 0; the hold counter is 0.
  - The datapath clears its card registers on the same reset.
- First rising edge with `resetb` high: RST→P1.
- A strobe asserted in state S is captured by the datapath on the edge that leaves S. Scores are therefore valid in the following state: CHECK sees all four cards, BCHK sees `pcard3`, DONE sees the final hand.
- Edge count from reset release to DONE: 6 (natural or both stand), 7 (banker-only draw), 8 (player draws, banker stands), 9 (both draw).
- Without `AUTO_REDEAL_EN`, DONE is terminal until reset.

## Configuration
- `BACCARAT_AUTO_REDEAL_EN` defined:
  - DONE holds for `HOLD_CYCLES` cycles, counted by an internal counter that clears on DONE entry.
  - Then one RST cycle with `clear_hand`=1, lights 0, then P1.
  - Lights are valid for all `HOLD_CYCLES` DONE cycles.
- Undefined: no hold counter, `clear_hand` tied 0, DONE terminal.

## Test plan
- Natural, player wins:
  - Stimulus: P=8,K (8); D=2,3 (5).
  - Required: only strobes P1,D1,P2,D2; DONE at edge 6; `player_win_light`=1, `dealer_win_light`=0.
- Player draws, banker stands:
  - Stimulus: P=2,3 (5); D=4,3 (7); `pcard3`=9 (player 4).
  - Required: `load_pcard3` at edge 6, no `load_dcard3`, DONE at edge 8, dealer light only.
- Banker 6 draws on v=6:
  - Stimulus: P=A,4 (5); D=3,3 (6); `pcard3`=6 (player 1); dealer third card 2 (8).
  - Required: `load_dcard3` in the cycle after BCHK; DONE at edge 9; dealer light only.
- Banker 3 stands on v=8:
  - Stimulus: P=A,4; D=A,2; `pcard3`=8 (player 3); banker 3.
  - Required: BCHK→DONE, no `load_dcard3`, both lights (tie 3–3).
- Player stands, banker draws, tie:
  - Stimulus: P=Q,6 (6); D=A,2 (3); dealer third card 3 (6).
  - Required: CHECK→D3 at edge 6, DONE at edge 7, both lights.
- Reset mid-operation:
  - Stimulus: drop `resetb` while in P3.
  - Required: all outputs 0 within the same cycle; after release, P1 follows on the first edge.
- With the macro defined and `HOLD_CYCLES`=8:
  - Required: lights high for 8 cycles, then one `clear_hand` pulse, then `load_pcard1`.

Source files
------------

// File: rtl/baccarat_deal_fsm.sv
// baccarat_deal_fsm: deals four cards, applies the third-card rules, then lights the winner.
// Latency: one state per slow_clock edge; DONE is reached 6 to 9 edges after reset release.
// Backpressure: none. BACCARAT_AUTO_REDEAL_EN enables a HOLD_CYCLES hold in DONE, then a clear and redeal.
module baccarat_deal_fsm #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_hand,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    s_rst,
    s_p1,
    s_d1,
    s_p2,
    s_d2,
    s_check,
    s_p3,
    s_bchk,
    s_d3,
    s_done
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] pv;
  logic       natural;
  logic       player_draws;
  logic       dealer_low;
  logic       banker_draws;
  logic       hold_done;
  logic       redeal;

  // A hold of zero cycles would make DONE invisible; reject it at elaboration.
  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("HOLD_CYCLES must be at least 1");
  end

  // Face value of the player's third card: only codes 1-9 count, tens and pictures are zero.
  always_comb begin
    pv = 4'd0;
    if (pcard3 >= 4'd1 && pcard3 <= 4'd9) begin
      pv = pcard3;
    end
  end

  // Two-card decisions; out-of-range scores (10-15) fall into the natural branch.
  always_comb begin
    natural      = (pscore >= 4'd8) || (dscore >= 4'd8);
    player_draws = (pscore <= 4'd5);
    dealer_low   = (dscore <= 4'd5);
  end

  // Banker rule after the player has drawn; scores above 6 (including 10-15) stand.
  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pv != 4'd8);
      4'd4:             banker_draws = (pv >= 4'd2) && (pv <= 4'd7);
      4'd5:             banker_draws = (pv >= 4'd4) && (pv <= 4'd7);
      4'd6:             banker_draws = (pv >= 4'd6) && (pv <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

`ifdef BACCARAT_AUTO_REDEAL_EN
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] hold_cnt;

  // Last DONE cycle of the hold window.
  always_comb hold_done = (hold_cnt == CW'(HOLD_CYCLES - 1));

  // Hold counter: runs only while staying in DONE, so it is zero on DONE entry and everywhere else.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      hold_cnt <= '0;
    end else if (state == s_done && state_nxt == s_done) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Marks the RST cycle entered from DONE, which is the only RST that clears the hand.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      redeal <= 1'b0;
    end else begin
      redeal <= (state == s_done) && hold_done;
    end
  end
`else
  // Without redeal DONE never exits and the hand is never cleared by this block.
  always_comb begin
    hold_done = 1'b0;
    redeal    = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= s_rst;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt        = state;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    clear_hand       = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state)
      s_rst: begin
        clear_hand = redeal;
        state_nxt  = s_p1;
      end
      s_p1: begin
        load_pcard1 = 1'b1;
        state_nxt   = s_d1;
      end
      s_d1: begin
        load_dcard1 = 1'b1;
        state_nxt   = s_p2;
      end
      s_p2: begin
        load_pcard2 = 1'b1;
        state_nxt   = s_d2;
      end
      s_d2: begin
        load_dcard2 = 1'b1;
        state_nxt   = s_check;
      end
      s_check: begin
        if (natural) begin
          state_nxt = s_done;
        end else if (player_draws) begin
          state_nxt = s_p3;
        end else if (dealer_low) begin
          state_nxt = s_d3;
        end else begin
          state_nxt = s_done;
        end
      end
      s_p3: begin
        load_pcard3 = 1'b1;
        state_nxt   = s_bchk;
      end
      s_bchk: begin
        state_nxt = banker_draws ? s_d3 : s_done;
      end
      s_d3: begin
        load_dcard3 = 1'b1;
        state_nxt   = s_done;
      end
      s_done: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        if (hold_done) begin
          state_nxt = s_rst;
        end
      end
      default: begin
        state_nxt = s_rst;
      end
    endcase
  end

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// tb_baccarat_deal_fsm: plays directed and random hands against a card-level reference model.
// Latency: each hand takes up to 9 edges plus settling; all waits are bounded.
// Backpressure: none; a scoreboard queue decouples the driver from the negedge monitor.
module tb_baccarat_deal_fsm;

  localparam int HOLD = 8;

  typedef struct {
    int         kind;    // 0..5 = P1,D1,P2,D2,P3,D3 strobe, 6 = final result
    int         edge_n;  // rising edges since reset release
    logic [1:0] lights;  // {player, dealer}
  } ev_t;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clear_hand, player_win_light, dealer_win_light;

  ev_t        q[$];
  int         checks   = 0;
  int         failures = 0;
  int         deck[6];
  int         pc[3];
  int         dc[3];
  int         edge_cnt;
  bit         mon_en   = 1'b0;
  bit         res_seen = 1'b0;
  logic [1:0] exp_lights;

  always #5 slow_clock = ~slow_clock;

  baccarat_deal_fsm #(.HOLD_CYCLES(HOLD)) dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore          (pscore),
    .dscore          (dscore),
    .pcard3          (pcard3),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .clear_hand      (clear_hand),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light)
  );

  function automatic int cval(int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic bit banker_draws(int d, int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v inside {[2:7]};
    if (d == 5) return v inside {[4:7]};
    if (d == 6) return v inside {[6:7]};
    return 1'b0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
            clear_hand, player_win_light, dealer_win_light};
  endfunction

  // Datapath stand-in: card registers captured on strobes, scores are hand totals mod 10.
  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb || clear_hand) begin
      pc[0] <= 0; pc[1] <= 0; pc[2] <= 0;
      dc[0] <= 0; dc[1] <= 0; dc[2] <= 0;
    end else begin
      if (load_pcard1) pc[0] <= deck[0];
      if (load_dcard1) dc[0] <= deck[1];
      if (load_pcard2) pc[1] <= deck[2];
      if (load_dcard2) dc[1] <= deck[3];
      if (load_pcard3) pc[2] <= deck[4];
      if (load_dcard3) dc[2] <= deck[5];
    end
  end

  always_comb begin
    pscore = 4'((cval(pc[0]) + cval(pc[1]) + cval(pc[2])) % 10);
    dscore = 4'((cval(dc[0]) + cval(dc[1]) + cval(dc[2])) % 10);
    pcard3 = 4'(pc[2]);
  end

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  // Monitor: pops the next expected event whenever the DUT strobes or first shows a result.
  always @(negedge slow_clock) begin
    logic [5:0] s;
    logic [1:0] l;
    ev_t        e;
    s = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    l = {player_win_light, dealer_win_light};
    if (mon_en && resetb) begin
      if (s != 6'd0) begin
        chk("lights_while_dealing", int'(l), 0);
        if (q.size() == 0) begin
          chk("unexpected_strobe", int'(s), 0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", int'(s), 1 << e.kind);
          chk("strobe_edge", edge_cnt, e.edge_n);
        end
      end
      if (l != 2'b00 && !res_seen) begin
        res_seen = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_result", int'(l), 0);
        end else begin
          e = q.pop_front();
          chk("result_order", e.kind, 6);
          chk("result_lights", int'(l), int'(e.lights));
          chk("done_edge", edge_cnt, e.edge_n);
        end
      end
    end
  end

  task automatic push(int kind, int edge_n, logic [1:0] lights);
    ev_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    e.lights = lights;
    q.push_back(e);
  endtask

  // Reference: play the hand from the deck by the table rules and queue every expected event.
  task automatic expect_game();
    int p, d, pv, e;
    p = (cval(deck[0]) + cval(deck[2])) % 10;
    d = (cval(deck[1]) + cval(deck[3])) % 10;
    push(0, 1, 2'b00); push(1, 2, 2'b00); push(2, 3, 2'b00); push(3, 4, 2'b00);
    if (p >= 8 || d >= 8) begin
      e = 6;
    end else if (p <= 5) begin
      push(4, 6, 2'b00);
      pv = cval(deck[4]);
      p  = (p + pv) % 10;
      if (banker_draws(d, pv)) begin
        push(5, 8, 2'b00);
        d = (d + cval(deck[5])) % 10;
        e = 9;
      end else begin
        e = 8;
      end
    end else if (d <= 5) begin
      push(5, 6, 2'b00);
      d = (d + cval(deck[5])) % 10;
      e = 7;
    end else begin
      e = 6;
    end
    exp_lights = {p >= d, d >= p};
    push(6, e, exp_lights);
  endtask

  task automatic run_game();
    int n;
    resetb   = 1'b0;
    mon_en   = 1'b0;
    q.delete();
    res_seen = 1'b0;
    @(negedge slow_clock);
    chk("reset_outputs", int'(all_outs()), 0);
    expect_game();
    mon_en = 1'b1;
    resetb = 1'b1;
    n = 0;
    while (!res_seen && n < 40) begin
      @(negedge slow_clock);
      #1;
      n++;
    end
    if (!res_seen) chk("done_timeout", 0, 1);
`ifdef BACCARAT_AUTO_REDEAL_EN
    begin
      int hold;
      mon_en = 1'b0;
      hold   = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge slow_clock);
        if ({player_win_light, dealer_win_light} == 2'b00) break;
        hold++;
      end
      chk("hold_cycles", hold, HOLD);
      chk("clear_hand_pulse", int'(clear_hand), 1);
      @(negedge slow_clock);
      chk("redeal_p1", int'(load_pcard1), 1);
      chk("clear_hand_single", int'(clear_hand), 0);
    end
`else
    repeat (3) @(negedge slow_clock);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("done_terminal_lights", int'({player_win_light, dealer_win_light}), int'(exp_lights));
`endif
  endtask

  task automatic reset_mid();
    int n;
    resetb   = 1'b0;
    mon_en   = 1'b0;
    q.delete();
    res_seen = 1'b0;
    deck     = '{2, 4, 3, 3, 9, 5};
    @(negedge slow_clock);
    resetb = 1'b1;
    n = 0;
    while (!load_pcard3 && n < 20) begin
      @(negedge slow_clock);
      n++;
    end
    chk("reach_p3", int'(load_pcard3), 1);
    resetb = 1'b0;
    #1;
    chk("midreset_outputs", int'(all_outs()), 0);
    @(negedge slow_clock);
    chk("midreset_held", int'(all_outs()), 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    #1;
    chk("post_reset_p1", int'(load_pcard1), 1);
    chk("post_reset_edge", edge_cnt, 1);
  endtask

  initial begin
    deck = '{8, 2, 13, 3, 1, 1};  run_game();  // natural, player 8 vs 5
    deck = '{2, 4, 3, 3, 9, 7};   run_game();  // player draws to 4, banker 7 stands
    deck = '{1, 3, 4, 3, 6, 2};   run_game();  // banker 6 draws on 6, dealer 8 wins
    deck = '{1, 1, 4, 2, 8, 5};   run_game();  // banker 3 stands on 8, tie 3-3
    deck = '{12, 1, 6, 2, 4, 3};  run_game();  // player stands 6, banker draws to 6, tie
    reset_mid();
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < 6; i++) deck[i] = int'($urandom_range(1, 13));
      run_game();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
